// File: rtl/mc14500b_icu.sv
// MC14500B-style 1-bit industrial control unit: one instruction per valid cycle,
// result register, gated input/output enables, skip handling and one-cycle flags.
module mc14500b_icu (
    input  logic       clk,
    input  logic       rst,
    input  logic       ins_valid,
    input  logic [3:0] ins,
    input  logic       data_in,
    input  logic [2:0] ia,
    output logic       rr,
    output logic       data_out,
    output logic [2:0] wa,
    output logic       write,
    output logic       jmp,
    output logic       rtn,
    output logic       flag0,
    output logic       flagf
);

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    logic       rr_q, rr_d;
    logic       ien_q, ien_d;
    logic       oen_q, oen_d;
    logic       skip_q, skip_d;
    logic       data_out_q, data_out_d;
    logic [2:0] wa_q, wa_d;
    logic       write_q, write_d;
    logic       jmp_q, jmp_d;
    logic       rtn_q, rtn_d;
    logic       flag0_q, flag0_d;
    logic       flagf_q, flagf_d;
    logic       d_eff;

    // Instruction decode and next-state; pulses default low, held state defaults to current value.
    always_comb begin
        rr_d       = rr_q;
        ien_d      = ien_q;
        oen_d      = oen_q;
        skip_d     = skip_q;
        data_out_d = data_out_q;
        wa_d       = wa_q;
        write_d    = 1'b0;
        jmp_d      = 1'b0;
        rtn_d      = 1'b0;
        flag0_d    = 1'b0;
        flagf_d    = 1'b0;
        d_eff      = data_in & ien_q;

        if (rst) begin
            rr_d       = 1'b0;
            ien_d      = 1'b0;
            oen_d      = 1'b0;
            skip_d     = 1'b0;
            data_out_d = 1'b0;
            wa_d       = 3'b000;
        end else if (ins_valid) begin
            if (skip_q) begin
                // Discarded instruction only consumes the pending skip.
                skip_d = 1'b0;
            end else begin
                case (ins)
                    OP_NOPO: flag0_d = 1'b1;
                    OP_LD:   rr_d = d_eff;
                    OP_LDC:  rr_d = ~d_eff;
                    OP_AND:  rr_d = rr_q & d_eff;
                    OP_ANDC: rr_d = rr_q & ~d_eff;
                    OP_OR:   rr_d = rr_q | d_eff;
                    OP_ORC:  rr_d = rr_q | ~d_eff;
                    OP_XNOR: rr_d = ~(rr_q ^ d_eff);
                    OP_STO, OP_STOC: begin
                        if (oen_q) begin
                            data_out_d = (ins == OP_STOC) ? ~rr_q : rr_q;
                            wa_d       = ia;
                            write_d    = 1'b1;
                        end else begin
                            write_d    = 1'b0;
                        end
                    end
                    OP_IEN:  ien_d = data_in;
                    OP_OEN:  oen_d = data_in;
                    OP_JMP:  jmp_d = 1'b1;
                    OP_RTN: begin
                        rtn_d  = 1'b1;
                        skip_d = 1'b1;
                    end
                    OP_SKZ:  skip_d = ~rr_q;
                    OP_NOPF: flagf_d = 1'b1;
                    default: flag0_d = 1'b0;
                endcase
            end
        end else begin
            skip_d = skip_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        rr_q       <= rr_d;
        ien_q      <= ien_d;
        oen_q      <= oen_d;
        skip_q     <= skip_d;
        data_out_q <= data_out_d;
        wa_q       <= wa_d;
        write_q    <= write_d;
        jmp_q      <= jmp_d;
        rtn_q      <= rtn_d;
        flag0_q    <= flag0_d;
        flagf_q    <= flagf_d;
    end

    assign rr       = rr_q;
    assign data_out = data_out_q;
    assign wa       = wa_q;
    assign write    = write_q;
    assign jmp      = jmp_q;
    assign rtn      = rtn_q;
    assign flag0    = flag0_q;
    assign flagf    = flagf_q;

endmodule

// File: tb/tb_mc14500b_icu.sv
// Scoreboard bench for mc14500b_icu: a reference model pushes expected outputs
// when an instruction is driven; they are popped and compared after the clock edge.
module tb_mc14500b_icu;

    logic       clk = 1'b0;
    logic       rst, ins_valid, data_in;
    logic [3:0] ins;
    logic [2:0] ia;
    logic       rr, data_out, write, jmp, rtn, flag0, flagf;
    logic [2:0] wa;

    int errors = 0;
    int checks = 0;

    mc14500b_icu dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins(ins), .data_in(data_in), .ia(ia),
        .rr(rr), .data_out(data_out), .wa(wa), .write(write),
        .jmp(jmp), .rtn(rtn), .flag0(flag0), .flagf(flagf)
    );

    always #5 clk = ~clk;

    // reference model state
    logic       m_rr, m_ien, m_oen, m_skip, m_dout, m_wr, m_jmp, m_rtn, m_f0, m_ff;
    logic [2:0] m_wa;

    typedef struct {
        string      tag;
        logic [9:0] vec;
    } sb_entry_t;
    sb_entry_t sb_q[$];

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [3:0] op,
                              input logic din, input logic [2:0] addr);
        logic d;
        m_wr = 1'b0; m_jmp = 1'b0; m_rtn = 1'b0; m_f0 = 1'b0; m_ff = 1'b0;
        d = din && m_ien;
        if (r) begin
            {m_rr, m_ien, m_oen, m_skip, m_dout} = 5'b00000;
            m_wa = 3'b000;
        end else if (v && m_skip) begin
            m_skip = 1'b0;
        end else if (v) begin
            case (op)
                4'h0: m_f0 = 1'b1;
                4'h1: m_rr = d;
                4'h2: m_rr = !d;
                4'h3: m_rr = m_rr && d;
                4'h4: m_rr = m_rr && !d;
                4'h5: m_rr = m_rr || d;
                4'h6: m_rr = m_rr || !d;
                4'h7: m_rr = (m_rr == d);
                4'h8, 4'h9: if (m_oen) begin
                    m_wr = 1'b1; m_wa = addr;
                    m_dout = (op == 4'h8) ? m_rr : !m_rr;
                end
                4'hA: m_ien = din;
                4'hB: m_oen = din;
                4'hC: m_jmp = 1'b1;
                4'hD: begin m_rtn = 1'b1; m_skip = 1'b1; end
                4'hE: m_skip = (m_rr == 1'b0);
                default: m_ff = 1'b1;
            endcase
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic [3:0] op,
                        input logic din, input logic [2:0] addr);
        sb_entry_t e;
        @(negedge clk);
        rst = r; ins_valid = v; ins = op; data_in = din; ia = addr;
        model_step(r, v, op, din, addr);
        e.tag = tag;
        e.vec = {m_rr, m_dout, m_wa, m_wr, m_jmp, m_rtn, m_f0, m_ff};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 16'd1, 16'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, {6'd0, rr, data_out, wa, write, jmp, rtn, flag0, flagf}, {6'd0, e.vec});
        end
    endtask

    task automatic ex(input string tag, input logic [3:0] op, input logic din, input logic [2:0] addr);
        step(tag, 1'b0, 1'b1, op, din, addr);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        step("rst", 1'b1, 1'b0, 4'h0, 1'b0, 3'd0);
    endtask

    initial begin
        rst = 1'b1; ins_valid = 1'b0; ins = 4'h0; data_in = 1'b0; ia = 3'd0;
        do_reset();
        do_reset();
        check_eq("reset_outs", {6'd0, rr, data_out, wa, write, jmp, rtn, flag0, flagf}, 16'd0);

        // input enable gates LD data
        ex("ld_gated", 4'h1, 1'b1, 3'd0);
        check_eq("ld_gated_rr", {15'd0, rr}, 16'd0);
        ex("ien1", 4'hA, 1'b1, 3'd0);
        ex("ld1", 4'h1, 1'b1, 3'd0);
        check_eq("ld1_rr", {15'd0, rr}, 16'd1);
        ex("ldc1", 4'h2, 1'b1, 3'd0);
        check_eq("ldc1_rr", {15'd0, rr}, 16'd0);

        // basic store
        do_reset();
        ex("ien", 4'hA, 1'b1, 3'd0);
        ex("oen", 4'hB, 1'b1, 3'd0);
        ex("ld", 4'h1, 1'b1, 3'd0);
        ex("sto5", 4'h8, 1'b0, 3'd5);
        check_eq("sto5_wr_dout_wa", {11'd0, write, data_out, wa}, {11'd0, 1'b1, 1'b1, 3'd5});
        idle("sto5_after");
        check_eq("sto5_pulse_end", {15'd0, write}, 16'd0);

        // skip on zero
        ex("ldc_z", 4'h2, 1'b1, 3'd0);
        ex("skz", 4'hE, 1'b0, 3'd0);
        ex("ld_skipped", 4'h1, 1'b1, 3'd0);
        check_eq("skipped_rr", {15'd0, rr}, 16'd0);
        ex("ld_after_skip", 4'h1, 1'b1, 3'd0);
        check_eq("after_skip_rr", {15'd0, rr}, 16'd1);

        // output enable off blocks store; STOC with enable on
        ex("oen0", 4'hB, 1'b0, 3'd0);
        ex("sto_blocked", 4'h8, 1'b0, 3'd3);
        check_eq("sto_blocked", {11'd0, write, data_out, wa}, {11'd0, 1'b0, 1'b1, 3'd5});
        ex("oen1", 4'hB, 1'b1, 3'd0);
        ex("stoc3", 4'h9, 1'b0, 3'd3);
        check_eq("stoc3", {11'd0, write, data_out, wa}, {11'd0, 1'b1, 1'b0, 3'd3});

        // RTN skip survives idle cycles
        ex("rtn", 4'hD, 1'b0, 3'd0);
        check_eq("rtn_pulse", {15'd0, rtn}, 16'd1);
        idle("idle1"); idle("idle2"); idle("idle3");
        ex("jmp_skipped", 4'hC, 1'b0, 3'd0);
        check_eq("jmp_skipped", {15'd0, jmp}, 16'd0);
        ex("nopf", 4'hF, 1'b0, 3'd0);
        check_eq("nopf_flag", {15'd0, flagf}, 16'd1);
        ex("nopo", 4'h0, 1'b0, 3'd0);
        ex("jmp", 4'hC, 1'b0, 3'd0);

        // reset right after a store
        ex("ld_r", 4'h1, 1'b1, 3'd0);
        ex("sto6", 4'h8, 1'b0, 3'd6);
        step("rst_with_sto", 1'b1, 1'b1, 4'h8, 1'b1, 3'd7);
        check_eq("rst_after_sto", {11'd0, write, data_out, wa, rr}, 16'd0);
        idle("post_rst");

        // reset discards a pending skip
        ex("skz_pend", 4'hE, 1'b0, 3'd0);
        step("rst_with_skip", 1'b1, 1'b1, 4'h1, 1'b1, 3'd0);
        ex("nopo_after_rst", 4'h0, 1'b0, 3'd0);
        check_eq("skip_cleared", {15'd0, flag0}, 16'd1);

        // random instruction mix against the model
        ex("ien_r", 4'hA, 1'b1, 3'd0);
        ex("oen_r", 4'hB, 1'b1, 3'd0);
        for (int i = 0; i < 200; i++) begin
            step("rand", 1'b0, ($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
